// File: rtl/cache_2w_if.sv
// Purpose: bundles the CPU-side and memory-side signals of the two-way data cache.
// Latency: none; this is only wiring between the cache and its environment.
// Backpressure: the CPU waits for cpu_ready, and the cache holds mem_req until mem_ack.
// Ports: the cpu_* request/response signals, flush, the mem_* req/ack channel and the
//        hit/miss counters. The slave modport is the cache; the master modport is the
//        CPU together with the memory.
interface cache_2w_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int CNT_WIDTH     = 32
) ();
    logic                     cpu_req;
    logic                     cpu_we;
    logic [ADDRESS_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0]    cpu_wdata;
    logic                     flush;
    logic                     cpu_ready;
    logic [DATA_WIDTH-1:0]    cpu_rdata;
    logic                     hit;
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     mem_ack;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic [CNT_WIDTH-1:0]     hit_cnt;
    logic [CNT_WIDTH-1:0]     miss_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_ack, mem_rdata,
        output cpu_ready, cpu_rdata, hit, mem_req, mem_we, mem_addr, mem_wdata,
               hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_ack, mem_rdata,
        input  cpu_ready, cpu_rdata, hit, mem_req, mem_we, mem_addr, mem_wdata,
               hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_2w.sv
// Purpose: two-way set-associative data cache with write-through, no write-allocate,
//          LRU replacement, flush and saturating hit/miss counters.
// Latency: a load hit completes in the request cycle. A miss or a store completes in
//          the cycle mem_ack arrives; mem_req goes high one cycle after the request.
// Backpressure: one request is outstanding at a time. The CPU holds its request until
//          cpu_ready, and the cache holds mem_req until mem_ack.
// Ports: clk, rst (synchronous, active low) and bus (cache_2w_if.slave).
module cache_2w #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int SET_BITS      = 3,
    parameter int CNT_WIDTH     = 32
) (
    input logic       clk,
    input logic       rst,
    cache_2w_if.slave bus
);
    localparam int NSETS = 1 << SET_BITS;
    localparam int TAG_W = ADDRESS_WIDTH - SET_BITS - 2;
    localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = ~(ADDRESS_WIDTH'(3));

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t state_q, state_d;

    // Per-set state. Only the valid and LRU bits are reset; tags and data are not.
    logic [NSETS-1:0]      valid0_q, valid1_q;
    logic [NSETS-1:0]      lru_q;            // 1 means way1 is the least recently used way
    logic [TAG_W-1:0]      tag0_q  [NSETS];
    logic [TAG_W-1:0]      tag1_q  [NSETS];
    logic [DATA_WIDTH-1:0] data0_q [NSETS];
    logic [DATA_WIDTH-1:0] data1_q [NSETS];

    // The request is captured when it is accepted in IDLE, so the memory side
    // stays stable for the whole FILL or WRITE.
    logic [ADDRESS_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0]    req_wdata_q;
    logic                     wr_hit_q;
    logic                     wr_way_q;

    logic                 mem_req_q;
    logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

    // Lookup on the live CPU address
    logic [SET_BITS-1:0] cpu_set;
    logic [TAG_W-1:0]    cpu_tag;
    logic                hit0, hit1, lookup_hit;

    assign cpu_set    = bus.cpu_addr[SET_BITS+1:2];
    assign cpu_tag    = bus.cpu_addr[ADDRESS_WIDTH-1:SET_BITS+2];
    assign hit0       = valid0_q[cpu_set] && (tag0_q[cpu_set] == cpu_tag);
    assign hit1       = valid1_q[cpu_set] && (tag1_q[cpu_set] == cpu_tag);
    assign lookup_hit = hit0 || hit1;

    // Fields of the captured request, and victim selection for a fill
    logic [SET_BITS-1:0] req_set;
    logic [TAG_W-1:0]    req_tag;
    logic                victim;

    assign req_set = req_addr_q[SET_BITS+1:2];
    assign req_tag = req_addr_q[ADDRESS_WIDTH-1:SET_BITS+2];
    // Fill an empty way first (way0 before way1); otherwise replace the LRU way.
    assign victim  = !valid0_q[req_set] ? 1'b0 :
                     !valid1_q[req_set] ? 1'b1 : lru_q[req_set];

    // Control and outputs from the combinational half of the FSM
    logic                  ready_c, hit_c;
    logic [DATA_WIDTH-1:0] rdata_c;
    logic                  do_flush, accept, cnt_hit, cnt_miss;
    logic                  touch, touch_way;
    logic [SET_BITS-1:0]   touch_set;
    logic                  data_we, tag_we, arr_way;
    logic [DATA_WIDTH-1:0] arr_data;

    always_comb begin
        state_d   = state_q;
        ready_c   = 1'b0;
        hit_c     = 1'b0;
        rdata_c   = '0;
        do_flush  = 1'b0;
        accept    = 1'b0;
        cnt_hit   = 1'b0;
        cnt_miss  = 1'b0;
        touch     = 1'b0;
        touch_way = 1'b0;
        touch_set = cpu_set;
        data_we   = 1'b0;
        tag_we    = 1'b0;
        arr_way   = 1'b0;
        arr_data  = bus.mem_rdata;
        // While rst is low, every output and every write enable stays at its default.
        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.flush) begin
                        do_flush = 1'b1;       // a request in this cycle waits for the next one
                    end else if (bus.cpu_req) begin
                        accept   = 1'b1;
                        hit_c    = lookup_hit;
                        cnt_hit  = lookup_hit;
                        cnt_miss = !lookup_hit;
                        if (bus.cpu_we) begin
                            state_d = WRITE;
                        end else if (lookup_hit) begin
                            ready_c   = 1'b1;
                            rdata_c   = hit1 ? data1_q[cpu_set] : data0_q[cpu_set];
                            touch     = 1'b1;
                            touch_way = hit1;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        ready_c   = 1'b1;
                        rdata_c   = bus.mem_rdata;   // return the fill data in the same cycle
                        data_we   = 1'b1;
                        tag_we    = 1'b1;
                        arr_way   = victim;
                        touch     = 1'b1;
                        touch_set = req_set;
                        touch_way = victim;
                        state_d   = IDLE;
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        ready_c = 1'b1;
                        state_d = IDLE;
                        // Update the cached copy only if the store hit; a miss does not allocate.
                        if (wr_hit_q) begin
                            data_we   = 1'b1;
                            arr_way   = wr_way_q;
                            arr_data  = req_wdata_q;
                            touch     = 1'b1;
                            touch_set = req_set;
                            touch_way = wr_way_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State that is reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            valid0_q   <= '0;
            valid1_q   <= '0;
            lru_q      <= '0;
            mem_req_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            // mem_req rises on the edge that enters FILL/WRITE and falls on the edge after ack.
            mem_req_q <= (state_d == FILL) || (state_d == WRITE);
            if (do_flush) begin
                valid0_q <= '0;
                valid1_q <= '0;
                lru_q    <= '0;
            end
            if (touch) begin
                lru_q[touch_set] <= ~touch_way;
            end
            if (tag_we) begin
                if (arr_way) valid1_q[req_set] <= 1'b1;
                else         valid0_q[req_set] <= 1'b1;
            end
            if (cnt_hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
            end
            if (cnt_miss && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    // Datapath state that is not reset. All enables are already low while rst is low.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr_q  <= bus.cpu_addr;
            req_wdata_q <= bus.cpu_wdata;
            wr_hit_q    <= lookup_hit;
            wr_way_q    <= hit1;
        end
        if (data_we) begin
            if (arr_way) data1_q[req_set] <= arr_data;
            else         data0_q[req_set] <= arr_data;
        end
        if (tag_we) begin
            if (arr_way) tag1_q[req_set] <= req_tag;
            else         tag0_q[req_set] <= req_tag;
        end
    end

    assign bus.cpu_ready = ready_c;
    assign bus.cpu_rdata = rdata_c;
    assign bus.hit       = hit_c;
    assign bus.mem_req   = rst && mem_req_q;
    assign bus.mem_we    = rst && (state_q == WRITE);
    assign bus.mem_addr  = req_addr_q & WORD_MASK;
    assign bus.mem_wdata = req_wdata_q;
    assign bus.hit_cnt   = hit_cnt_q;
    assign bus.miss_cnt  = miss_cnt_q;
endmodule
